// File: rtl/cpu3_pipeline_top.sv
// rtl/cpu3_pipeline_top.sv - 16-bit 3-stage pipelined load/store CPU with internal memories
module cpu3_pipeline_top #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 512
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_BYTES);

  typedef enum logic [3:0] {K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_DIV, K_LW, K_SW} kind_t;

  logic [15:0] imem [IMEM_WORDS];
  logic [15:0] rf [16];
  logic [7:0]  dmem [DMEM_BYTES];

  logic [15:0] pc, pc_next, pc_inc, target;
  logic        halted;

  kind_t       s2_kind;
  logic [3:0]  s2_ra, s2_imm4;
  logic [15:0] s2_a, s2_b;
  logic        alu_ra_we, alu_r0_we;
  logic [15:0] alu_ra_val, alu_r0_val, alu_addr;

  logic        s3_ra_we, s3_r0_we, s3_lw, s3_sw;
  logic [3:0]  s3_ra;
  logic [15:0] s3_ra_val, s3_r0_val, s3_sdata;
  logic [DAW-2:0] s3_word;
  logic [DAW-1:0] s3_even, s3_odd;
  logic [15:0] wb_val;
  logic        unused_addr_bits;

  assign s3_even = {s3_word, 1'b0};
  assign s3_odd  = {s3_word, 1'b1};
  assign wb_val  = s3_lw ? {dmem[s3_even], dmem[s3_odd]} : s3_ra_val;
  assign unused_addr_bits = ^{alu_addr[15:DAW], alu_addr[0]};

  // R0 writes are checked before ra writes so MUL/DIV targeting R0 resolves like the register file
  function automatic logic [15:0] fwd(input logic [3:0] x);
    if (alu_r0_we && x == 4'd0) return alu_r0_val;
    if (alu_ra_we && s2_ra == x) return alu_ra_val;
    if (s3_r0_we && x == 4'd0) return s3_r0_val;
    if (s3_ra_we && s3_ra == x) return wb_val;
    return rf[x];
  endfunction

  logic [15:0] ins, ra_val, rb_val, r0_val, d_b;
  logic [3:0]  op, ra, rb, fn;
  kind_t       d_kind;
  logic        need_ra, need_rb, need_r0, is_halt, taken, stall;

  assign ins    = imem[pc[IAW:1]];
  assign op     = ins[15:12];
  assign ra     = ins[11:8];
  assign rb     = ins[7:4];
  assign fn     = ins[3:0];
  assign ra_val = fwd(ra);
  assign rb_val = fwd(rb);
  assign r0_val = fwd(4'd0);
  assign pc_inc = pc + 16'd2;
  assign target = (op == 4'hC) ? pc_inc + {{3{ins[11]}}, ins[11:0], 1'b0}
                               : pc_inc + {{7{ins[7]}}, ins[7:0], 1'b0};

  always_comb begin
    d_kind  = K_NOP;
    d_b     = rb_val;
    need_ra = 1'b0;
    need_rb = 1'b0;
    need_r0 = 1'b0;
    is_halt = 1'b0;
    taken   = 1'b0;
    if (!halted) begin
      case (op)
        4'h0: begin
          need_ra = 1'b1;
          need_rb = 1'b1;
          case (fn)
            4'h0: d_kind = K_ADD;
            4'h1: d_kind = K_SUB;
            4'h2: d_kind = K_AND;
            4'h3: d_kind = K_OR;
            4'h4: d_kind = K_MUL;
            4'h5: d_kind = K_DIV;
            default: begin
              need_ra = 1'b0;
              need_rb = 1'b0;
            end
          endcase
        end
        4'h1: begin
          d_kind  = K_ADD;
          d_b     = {{8{ins[7]}}, ins[7:0]};
          need_ra = 1'b1;
        end
        4'h8: begin
          d_kind  = K_LW;
          need_rb = 1'b1;
        end
        4'hB: begin
          d_kind  = K_SW;
          need_ra = 1'b1;
          need_rb = 1'b1;
        end
        4'h4, 4'h5, 4'h6: begin
          need_ra = 1'b1;
          need_r0 = 1'b1;
          if (op == 4'h4)      taken = $signed(ra_val) < $signed(r0_val);
          else if (op == 4'h5) taken = $signed(ra_val) > $signed(r0_val);
          else                 taken = ra_val == r0_val;
        end
        4'hC: taken = 1'b1;
        4'hF: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

  // A load still in stage 2 has no data yet; wait one cycle and pick it up from stage 3
  assign stall = (s2_kind == K_LW) &&
                 ((need_ra && ra == s2_ra) || (need_rb && rb == s2_ra) || (need_r0 && s2_ra == 4'd0));

  always_comb begin
    if (halted || is_halt || stall) pc_next = pc;
    else if (taken)                 pc_next = target;
    else                            pc_next = pc_inc;
  end

  logic signed [31:0] prod;
  logic        div_zero;
  logic [15:0] div_q, div_r;
  assign prod     = $signed(s2_a) * $signed(s2_b);
  assign div_zero = (s2_b == 16'd0);
  assign div_q    = div_zero ? 16'hFFFF : $signed(s2_a) / $signed(s2_b);
  assign div_r    = div_zero ? s2_a : $signed(s2_a) % $signed(s2_b);

  always_comb begin
    alu_ra_we  = 1'b0;
    alu_r0_we  = 1'b0;
    alu_ra_val = 16'h0000;
    alu_r0_val = 16'h0000;
    alu_addr   = s2_b + {{12{s2_imm4[3]}}, s2_imm4};
    case (s2_kind)
      K_ADD: begin alu_ra_we = 1'b1; alu_ra_val = s2_a + s2_b; end
      K_SUB: begin alu_ra_we = 1'b1; alu_ra_val = s2_a - s2_b; end
      K_AND: begin alu_ra_we = 1'b1; alu_ra_val = s2_a & s2_b; end
      K_OR:  begin alu_ra_we = 1'b1; alu_ra_val = s2_a | s2_b; end
      K_MUL: begin
        alu_ra_we = 1'b1; alu_r0_we = 1'b1;
        alu_ra_val = prod[15:0]; alu_r0_val = prod[31:16];
      end
      K_DIV: begin
        alu_ra_we = 1'b1; alu_r0_we = 1'b1;
        alu_ra_val = div_q; alu_r0_val = div_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= 16'h0000;
      halted   <= 1'b0;
      s2_kind  <= K_NOP;
      s3_ra_we <= 1'b0;
      s3_r0_we <= 1'b0;
      s3_lw    <= 1'b0;
      s3_sw    <= 1'b0;
    end else begin
      pc <= pc_next;
      if (is_halt) halted <= 1'b1;
      s2_kind   <= stall ? K_NOP : d_kind;
      s2_ra     <= ra;
      s2_a      <= ra_val;
      s2_b      <= d_b;
      s2_imm4   <= fn;
      s3_ra_we  <= alu_ra_we || (s2_kind == K_LW);
      s3_r0_we  <= alu_r0_we;
      s3_lw     <= (s2_kind == K_LW);
      s3_sw     <= (s2_kind == K_SW);
      s3_ra     <= s2_ra;
      s3_ra_val <= alu_ra_val;
      s3_r0_val <= alu_r0_val;
      s3_word   <= alu_addr[DAW-1:1];
      s3_sdata  <= s2_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (s3_ra_we) rf[s3_ra] <= wb_val;
      if (s3_r0_we) rf[0] <= s3_r0_val;
      if (s3_sw) begin
        dmem[s3_even] <= s3_sdata[15:8];
        dmem[s3_odd]  <= s3_sdata[7:0];
      end
    end
  end
endmodule

// File: tb/tb_cpu3_pipeline_top.sv
// tb/tb_cpu3_pipeline_top.sv - scoreboard bench for cpu3_pipeline_top
module tb_cpu3_pipeline_top;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu3_pipeline_top #(.IMEM_WORDS(256), .DMEM_BYTES(512)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  localparam int KREG = 0, KMEM = 1, KPC = 2;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] act;
  int          passed = 0;
  int          total = 0;

  function automatic logic [15:0] observe(input int kind, input int idx);
    if (kind == KREG) return dut.rf[idx];
    if (kind == KMEM) return {8'h00, dut.dmem[idx]};
    return dut.pc;
  endfunction

  task automatic expect_at(input int cyc, input int kind, input int idx, input logic [15:0] val, input string name);
    exp_t x;
    x.cyc = cyc; x.kind = kind; x.idx = idx; x.val = val; x.name = name;
    sb.push_back(x);
  endtask

  task automatic prep();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.imem[i] = 16'h0000;
    for (int i = 0; i < 16; i++)  dut.rf[i] = 16'h0000;
    for (int i = 0; i < 512; i++) dut.dmem[i] = 8'h00;
  endtask

  task automatic go();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    prep();
    for (int i = 0; i < 16; i++)  dut.rf[i] = 16'h1111 * i[15:0];
    for (int i = 0; i < 512; i++) dut.dmem[i] = i[7:0] ^ 8'h5A;
    for (int k = 0; k <= 10; k++) expect_at(k, KPC, 0, 16'(2 * k), "nop_pc");
    expect_at(10, KREG, 0, 16'h0000, "nop_r0");
    expect_at(10, KREG, 1, 16'h1111, "nop_r1");
    expect_at(10, KREG, 15, 16'hFFFF, "nop_r15");
    expect_at(10, KMEM, 0, 16'h005A, "nop_m0");
    expect_at(10, KMEM, 511, 16'h00A5, "nop_m511");
    go();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); act = observe(e.kind, e.idx); total++;
        if (act !== e.val) $display("FAIL %s @%0d: got %h expected %h", e.name, k, act, e.val);
        else passed++;
      end
    end
  endtask

  task automatic test_fwd_alu();
    prep();
    dut.rf[1] = 16'h0005; dut.rf[2] = 16'h0003;
    dut.imem[0] = 16'h0120; dut.imem[1] = 16'h0311; dut.imem[2] = 16'hF000;
    expect_at(0, KPC, 0, 16'h0000, "alu_reset_pc");
    expect_at(5, KREG, 1, 16'h0008, "add_r1");
    expect_at(5, KREG, 3, 16'hFFF8, "sub_r3_fwd");
    expect_at(5, KREG, 2, 16'h0003, "r2_kept");
    go();
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); act = observe(e.kind, e.idx); total++;
        if (act !== e.val) $display("FAIL %s @%0d: got %h expected %h", e.name, k, act, e.val);
        else passed++;
      end
    end
  endtask

  task automatic test_muldiv();
    prep();
    dut.rf[4] = 16'h0100; dut.rf[5] = 16'h0200; dut.rf[6] = 16'h0007; dut.rf[7] = 16'h0002;
    dut.imem[0] = 16'h0454; dut.imem[1] = 16'h0675; dut.imem[2] = 16'h0685; dut.imem[3] = 16'hF000;
    expect_at(3, KREG, 4, 16'h0000, "mul_lo");
    expect_at(3, KREG, 0, 16'h0002, "mul_hi");
    expect_at(4, KREG, 6, 16'h0003, "div_q");
    expect_at(4, KREG, 0, 16'h0001, "div_r");
    expect_at(5, KREG, 6, 16'hFFFF, "div0_q");
    expect_at(5, KREG, 0, 16'h0003, "div0_r");
    go();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); act = observe(e.kind, e.idx); total++;
        if (act !== e.val) $display("FAIL %s @%0d: got %h expected %h", e.name, k, act, e.val);
        else passed++;
      end
    end
  endtask

  task automatic test_load_use();
    prep();
    dut.dmem[0] = 8'h12; dut.dmem[1] = 8'h34;
    dut.imem[0] = 16'h8120; dut.imem[1] = 16'h0110; dut.imem[2] = 16'hF000;
    expect_at(1, KPC, 0, 16'h0002, "lu_pc1");
    expect_at(2, KPC, 0, 16'h0002, "lu_stall_pc");
    expect_at(3, KPC, 0, 16'h0004, "lu_one_stall");
    expect_at(3, KREG, 1, 16'h1234, "lw_r1");
    expect_at(6, KREG, 1, 16'h2468, "lu_add_r1");
    go();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); act = observe(e.kind, e.idx); total++;
        if (act !== e.val) $display("FAIL %s @%0d: got %h expected %h", e.name, k, act, e.val);
        else passed++;
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] prog [14];
    prog = '{16'h6102, 16'h1A01, 16'h1A01, 16'h1B01, 16'h1101, 16'h6102, 16'h1B01,
             16'h1B01, 16'h81C4, 16'h6102, 16'h1A01, 16'h1A01, 16'h1B01, 16'hF000};
    prep();
    for (int i = 0; i < 14; i++) dut.imem[i] = prog[i];
    dut.rf[0] = 16'h0007; dut.rf[1] = 16'h0007;
    dut.dmem[4] = 8'h00; dut.dmem[5] = 8'h07;
    expect_at(1, KPC, 0, 16'h0006, "beq_taken_pc");
    expect_at(4, KPC, 0, 16'h000C, "beq_fall_pc");
    expect_at(7, KPC, 0, 16'h0012, "beq_lw_pc");
    expect_at(8, KPC, 0, 16'h0012, "beq_lw_stall");
    expect_at(9, KPC, 0, 16'h0018, "beq_lw_taken");
    expect_at(14, KPC, 0, 16'h001A, "br_halt_pc");
    expect_at(14, KREG, 10, 16'h0000, "skipped_r10");
    expect_at(14, KREG, 11, 16'h0004, "exec_r11");
    expect_at(14, KREG, 1, 16'h0007, "br_r1");
    go();
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); act = observe(e.kind, e.idx); total++;
        if (act !== e.val) $display("FAIL %s @%0d: got %h expected %h", e.name, k, act, e.val);
        else passed++;
      end
    end
  endtask

  task automatic test_store_halt();
    prep();
    dut.rf[8] = 16'h2BCD; dut.rf[9] = 16'h579A;
    dut.imem[0] = 16'hB8C0; dut.imem[1] = 16'hB9C2; dut.imem[2] = 16'hF000;
    expect_at(0, KPC, 0, 16'h0000, "sw_reset_pc");
    expect_at(2, KPC, 0, 16'h0004, "halt_pc2");
    expect_at(3, KPC, 0, 16'h0004, "halt_pc3");
    expect_at(6, KMEM, 0, 16'h002B, "sw_m0");
    expect_at(6, KMEM, 1, 16'h00CD, "sw_m1");
    expect_at(6, KMEM, 2, 16'h0057, "sw_m2");
    expect_at(6, KMEM, 3, 16'h009A, "sw_m3");
    expect_at(6, KMEM, 4, 16'h0000, "sw_m4_kept");
    expect_at(20, KPC, 0, 16'h0004, "halt_pc20");
    go();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front(); act = observe(e.kind, e.idx); total++;
        if (act !== e.val) $display("FAIL %s @%0d: got %h expected %h", e.name, k, act, e.val);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    test_muldiv();
    test_load_use();
    test_branch();
    test_store_halt();
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      $display("FAIL %s: not sampled, expected %h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
